// File: rtl/veril_sweep_pkg.sv
// rtl/veril_sweep_pkg.sv - shared types and constants for the veril sweep checker
package veril_sweep_pkg;

   localparam int unsigned NUM_VECTORS = 16;
   localparam int unsigned IDX_W       = 4;
   localparam int unsigned ERR_W       = 5;
   // Wide enough for the largest reload value (255 + 2 with the synchronizer).
   localparam int unsigned CNT_W       = 9;

   localparam logic [NUM_VECTORS-1:0] NAND4_TT = 16'h7FFF;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } sweep_state_e;

endpackage

// File: rtl/veril_sweep_sync.sv
// rtl/veril_sweep_sync.sv - 2-flop synchronizer for the returned X signal
//
// Ports:
//   clk_i  : system clock, rising edge
//   rst_ni : asynchronous active-low reset, both flops clear to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output, two cycles of latency
module veril_sweep_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/veril_sweep_checker.sv
// rtl/veril_sweep_checker.sv - exhaustive 16-vector self-test around the veril NAND4 block
//
// Optional macro VERIL_SWEEP_SYNC_EN: routes x_i through a 2-flop synchronizer
// and stretches each vector by two cycles so the sample still matches it.
//
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   start, abort      : begin a sweep (from IDLE only) / cancel a running sweep
//   abcd_o, x_i       : vector driven to veril (A=bit3..D=bit0) and its X result
//   busy, done        : sweep in progress / one-cycle completion pulse
//   results_valid     : result outputs belong to a completed sweep
//   pass              : completed sweep with zero mismatches
//   fail_mask         : bit i set when vector i mismatched
//   err_count         : number of mismatching vectors
//   first_fail_idx    : lowest mismatching vector, qualified by first_fail_valid
module veril_sweep_checker
   import veril_sweep_pkg::*;
#(
   parameter logic [NUM_VECTORS-1:0] EXPECT_TT     = NAND4_TT,
   parameter int unsigned            SETTLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   output logic [IDX_W-1:0]       abcd_o,
   input  logic                   x_i,
   output logic                   busy,
   output logic                   done,
   output logic                   results_valid,
   output logic                   pass,
   output logic [NUM_VECTORS-1:0] fail_mask,
   output logic [ERR_W-1:0]       err_count,
   output logic [IDX_W-1:0]       first_fail_idx,
   output logic                   first_fail_valid
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

   logic x_cmp;

`ifdef VERIL_SWEEP_SYNC_EN
   // Two extra settle cycles cover the synchronizer latency.
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES + 2);

   veril_sweep_sync u_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (x_i),
      .q_o    (x_cmp)
   );
`else
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES);

   assign x_cmp = x_i;
`endif

   sweep_state_e           state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       abcd_q, abcd_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   rv_q, rv_d;
   logic                   pass_q, pass_d;
   logic [NUM_VECTORS-1:0] mask_q, mask_d;
   logic [ERR_W-1:0]       err_q, err_d;
   logic [IDX_W-1:0]       ffi_q, ffi_d;
   logic                   ffv_q, ffv_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         abcd_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rv_q    <= 1'b0;
         pass_q  <= 1'b0;
         mask_q  <= '0;
         err_q   <= '0;
         ffi_q   <= '0;
         ffv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         abcd_q  <= abcd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rv_q    <= rv_d;
         pass_q  <= pass_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         ffi_q   <= ffi_d;
         ffv_q   <= ffv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      abcd_d  = abcd_q;
      done_d  = 1'b0;
      rv_d    = rv_q;
      pass_d  = pass_q;
      mask_d  = mask_q;
      err_d   = err_q;
      ffi_d   = ffi_q;
      ffv_d   = ffv_q;

      unique case (state_q)
         IDLE: begin
            abcd_d = '0;
            if (start && !abort) begin
               rv_d    = 1'b0;
               pass_d  = 1'b0;
               mask_d  = '0;
               err_d   = '0;
               ffi_d   = '0;
               ffv_d   = 1'b0;
               idx_d   = '0;
               cnt_d   = RELOAD;
               state_d = SETTLE;
            end
         end

         SETTLE: begin
            if (abort) begin
               abcd_d  = '0;
               state_d = IDLE;
            end else begin
               abcd_d = idx_q;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  state_d = SAMPLE;
               end
            end
         end

         SAMPLE: begin
            if (abort) begin
               // Abort wins over this cycle's compare: the partial results stay as they were.
               abcd_d  = '0;
               state_d = IDLE;
            end else begin
               if (x_cmp != EXPECT_TT[idx_q]) begin
                  mask_d[idx_q] = 1'b1;
                  err_d         = err_q + ERR_W'(1);
                  if (!ffv_q) begin
                     ffi_d = idx_q;
                     ffv_d = 1'b1;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  // Results are published together with the done pulse.
                  done_d  = 1'b1;
                  rv_d    = 1'b1;
                  pass_d  = (err_d == '0);
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  abcd_d  = idx_q + IDX_W'(1);
                  cnt_d   = RELOAD;
                  state_d = SETTLE;
               end
            end
         end

         DONE: begin
            abcd_d  = '0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
   end

   assign abcd_o           = abcd_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign results_valid    = rv_q;
   assign pass             = pass_q;
   assign fail_mask        = mask_q;
   assign err_count        = err_q;
   assign first_fail_idx   = ffi_q;
   assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_veril_sweep_checker.sv
// tb/tb_veril_sweep_checker.sv - scoreboard bench for veril_sweep_checker
module tb_veril_sweep_checker;

   localparam int S = 2;
`ifdef VERIL_SWEEP_SYNC_EN
   localparam int P = S + 4;
`else
   localparam int P = S + 2;
`endif
   localparam logic [15:0] EXP_TT = 16'h7FFF;

   typedef struct {
      logic [15:0] mask;
      logic [4:0]  err;
      logic [3:0]  ffi;
      logic        ffv;
      logic        pass;
      int          done_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  abcd_o;
   logic        x_i;
   logic        busy, done, results_valid, pass, first_fail_valid;
   logic [15:0] fail_mask;
   logic [4:0]  err_count;
   logic [3:0]  first_fail_idx;

   logic [15:0] model_tt;
   logic [15:0] nand_tt;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        exp_q[$];
   exp_t        cur_exp;
   logic        chk_pending = 1'b0;

   veril_sweep_checker #(.EXPECT_TT(EXP_TT), .SETTLE_CYCLES(S)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .abort            (abort),
      .abcd_o           (abcd_o),
      .x_i              (x_i),
      .busy             (busy),
      .done             (done),
      .results_valid    (results_valid),
      .pass             (pass),
      .fail_mask        (fail_mask),
      .err_count        (err_count),
      .first_fail_idx   (first_fail_idx),
      .first_fail_valid (first_fail_valid)
   );

   // Gate model: X looks up the current vector in the chosen truth table.
   assign x_i = model_tt[abcd_o];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: compare the first nvec vectors of tt against the expected table.
   function automatic exp_t model(input logic [15:0] tt, input int nvec);
      exp_t e;
      e.mask = '0; e.err = '0; e.ffi = '0; e.ffv = 1'b0; e.done_cyc = 0;
      for (int v = 0; v < nvec; v++) begin
         if (tt[v] != EXP_TT[v]) begin
            e.mask[v] = 1'b1;
            e.err = e.err + 5'd1;
            if (!e.ffv) begin
               e.ffi = v[3:0];
               e.ffv = 1'b1;
            end
         end
      end
      e.pass = (e.err == 0);
      return e;
   endfunction

   // Monitor: pops the scoreboard on each done pulse, checks results one cycle later.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk_pending = 1'b0;
         end else begin
            if (chk_pending) begin
               chk("rv", results_valid, 1);
               chk("pass", pass, cur_exp.pass);
               chk("mask", fail_mask, cur_exp.mask);
               chk("err", err_count, cur_exp.err);
               chk("ffv", first_fail_valid, cur_exp.ffv);
               if (cur_exp.ffv) chk("ffi", first_fail_idx, cur_exp.ffi);
               chk_pending = 1'b0;
            end
            if (done) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", done, 0);
               end else begin
                  cur_exp = exp_q.pop_front();
                  chk("done_cycle", cyc, cur_exp.done_cyc);
                  chk_pending = 1'b1;
               end
            end
         end
      end
   end

   task automatic wait_cycle_ge(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_results();
      for (int i = 0; i < 20 && (exp_q.size() != 0 || chk_pending); i++) begin
         @(posedge clk);
      end
      #1;
      chk("results_timeout", (exp_q.size() != 0 || chk_pending), 0);
   endtask

   // Called at posedge+1; start is sampled at the end of the current cycle (cycle 0).
   task automatic run_sweep(input string tag, input logic [15:0] tt);
      exp_t e;
      int   c0;
      model_tt = tt;
      e = model(tt, 16);
      c0 = cyc;
      e.done_cyc = c0 + 16 * P + 1;
      exp_q.push_back(e);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         for (int j = 0; j < P; j++) begin
            @(negedge clk);
            chk({tag, " abcd"}, abcd_o, k);
            chk({tag, " busy"}, busy, 1);
         end
      end
      wait_results();
   endtask

   initial begin
      exp_t e1, e2, part;
      int   c0;
      for (int v = 0; v < 16; v++) nand_tt[v] = !(v == 15);
      model_tt = nand_tt;

      repeat (2) @(posedge clk);
      #1;
      chk("reset abcd", abcd_o, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset rv", results_valid, 0);
      chk("reset pass", pass, 0);
      chk("reset mask", fail_mask, 0);
      chk("reset err", err_count, 0);
      chk("reset ffi", first_fail_idx, 0);
      chk("reset ffv", first_fail_valid, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_sweep("nand", nand_tt);
      run_sweep("stuck1", 16'hFFFF);
      run_sweep("stuck0", 16'h0000);
      for (int r = 0; r < 3; r++) run_sweep("random", 16'($urandom));

      // start held high: back-to-back sweeps, extra starts ignored.
      model_tt = nand_tt;
      e1 = model(nand_tt, 16);
      e2 = e1;
      c0 = cyc;
      e1.done_cyc = c0 + 16 * P + 1;
      e2.done_cyc = c0 + 32 * P + 3;
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      start = 1'b1;
      wait_cycle_ge(c0 + 32 * P + 2);
      start = 1'b0;
      wait_results();

      // abort and start together in IDLE: abort wins.
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk("idle abort busy", busy, 0);
      @(posedge clk);
      #1;

      // Abort at cycle 20 with X stuck at 0.
      model_tt = 16'h0000;
      part = model(16'h0000, 19 / P);
      c0 = cyc;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_cycle_ge(c0 + 20);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort busy", busy, 0);
      chk("abort abcd", abcd_o, 0);
      chk("abort rv", results_valid, 0);
      chk("abort mask", fail_mask, part.mask);
      chk("abort err", err_count, part.err);
      repeat (P * 3) @(posedge clk);
      #1;
      chk("abort stays idle", busy, 0);

      // Asynchronous reset at cycle 30.
      model_tt = 16'hFFFF;
      c0 = cyc;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_cycle_ge(c0 + 30);
      chk("pre-reset busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("async abcd", abcd_o, 0);
      chk("async busy", busy, 0);
      chk("async done", done, 0);
      chk("async rv", results_valid, 0);
      chk("async mask", fail_mask, 0);
      chk("async err", err_count, 0);
      chk("async ffv", first_fail_valid, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_sweep("after_reset", nand_tt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
